// File: rtl/addsub_sequencer_pkg.sv
// addsub_seq_pkg
// Shared definitions for the time-multiplexed add/subtract sequencer:
//   - state_t : FSM encoding (IDLE, ACCUM, DONE)
//   - DEF_W / DEF_NREQ / DEF_NOPS : default width, requester count, operand count
//   - clog2() : ceiling log2, usable in parameter expressions
package addsub_seq_pkg;

  localparam int DEF_W    = 16;
  localparam int DEF_NREQ = 4;
  localparam int DEF_NOPS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Ceiling log2; clog2(1) = 0. The loop is bounded so it elaborates as a
  // constant function.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/addsub_sequencer_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin arbiter. The search starts at ptr and wraps
// modulo NREQ; the first asserted request wins. The caller owns the pointer
// register, so this block can be reused by any shared-resource controller.
// Ports:
//   req   in  NREQ : request vector
//   ptr   in  IW   : highest-priority index for this cycle
//   grant out NREQ : one-hot grant (all zero when no request)
//   idx   out IW   : encoded index of the granted requester
//   any   out 1    : at least one request is pending
module rr_arbiter
  import addsub_seq_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] cand;
  logic          found;

  // NREQ is a power of two, so wrapping is the natural IW-bit overflow.
  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      cand = ptr + IW'(off);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/addsub_sequencer.sv
// addsub_sequencer
// Shares one W-bit adder/subtractor between NREQ requesters. A granted job of
// NOPS operands (with a per-operand subtract mask) is latched, then reduced
// one operand per cycle, operand 0 first. Results wrap modulo 2^W.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester handshake, req_ready one-hot in IDLE
//   req_ops             : requester i operand k at [(i*NOPS+k)*W +: W]
//   req_sub             : bit i*NOPS+k set -> operand k of requester i subtracted
//   rsp_valid/rsp_ready : result handshake
//   rsp_data, rsp_id    : result and owning requester index
//   busy                : FSM outside IDLE
module addsub_sequencer
  import addsub_seq_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int NREQ = DEF_NREQ,
  parameter int NOPS = DEF_NOPS,
  localparam int IW  = clog2(NREQ),
  localparam int CW  = (NOPS > 1) ? clog2(NOPS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*NOPS*W-1:0] req_ops,
  input  logic [NREQ*NOPS-1:0]   req_sub,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [W-1:0]           rsp_data,
  output logic [IW-1:0]          rsp_id,
  output logic                   busy
);

  state_t                  state_reg, state_next;
  logic [W-1:0]            acc_reg, acc_next;
  logic [CW-1:0]           cnt_reg, cnt_next;
  logic [IW-1:0]           owner_reg, owner_next;
  logic [IW-1:0]           ptr_reg, ptr_next;
  logic [NOPS-1:0][W-1:0]  ops_reg;
  logic [NOPS-1:0]         sub_reg;

  logic [NREQ-1:0]         grant;
  logic [IW-1:0]           win_idx;
  logic                    any_req;
  logic                    take_job;

  logic [W-1:0]            operand;
  logic                    sub_bit;
  logic [W-1:0]            addend;
  logic [W-1:0]            sum;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (grant),
    .idx   (win_idx),
    .any   (any_req)
  );

  assign take_job = (state_reg == IDLE) && any_req;

  // Job storage needs no reset: it is only read in ACCUM, which is always
  // entered through a grant that reloads it.
  always_ff @(posedge clk) begin
    if (take_job) begin
      ops_reg <= req_ops[win_idx*NOPS*W +: NOPS*W];
      sub_reg <= req_sub[win_idx*NOPS +: NOPS];
    end
  end

  // Single adder: subtraction is acc + ~op + 1, with the sub bit as carry-in.
  assign operand = ops_reg[cnt_reg];
  assign sub_bit = sub_reg[cnt_reg];
  assign addend  = sub_bit ? ~operand : operand;
  assign sum     = acc_reg + addend + W'(sub_bit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      owner_reg <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      owner_reg <= owner_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          acc_next   = '0;
          cnt_next   = '0;
          owner_next = win_idx;
          ptr_next   = win_idx + IW'(1);
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        acc_next = sum;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == CW'(NOPS - 1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Grant is combinational from req_valid and ptr only; rsp_ready never
  // reaches it.
  assign req_ready = (state_reg == IDLE) ? grant : '0;
  assign rsp_valid = (state_reg == DONE);
  assign rsp_data  = acc_reg;
  assign rsp_id    = owner_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_addsub_sequencer.sv
module tb_addsub_sequencer;

  localparam int W    = 16;
  localparam int NREQ = 4;
  localparam int NOPS = 4;
  localparam int IW   = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*NOPS*W-1:0] req_ops;
  logic [NREQ*NOPS-1:0]   req_sub;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [W-1:0]           rsp_data;
  logic [IW-1:0]          rsp_id;
  logic                   busy;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  addsub_sequencer #(.W(W), .NREQ(NREQ), .NOPS(NOPS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ops   (req_ops),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic load(input int r, input logic [15:0] o0, input logic [15:0] o1,
                      input logic [15:0] o2, input logic [15:0] o3, input logic [3:0] m);
    req_ops[(r*NOPS+0)*W +: W] = o0;
    req_ops[(r*NOPS+1)*W +: W] = o1;
    req_ops[(r*NOPS+2)*W +: W] = o2;
    req_ops[(r*NOPS+3)*W +: W] = o3;
    req_sub[r*NOPS +: NOPS]    = m;
  endtask

  // Called just after a negedge; samples 1 time unit later, bounded to 20 cycles.
  task automatic wait_grant(input string name, input int exp_idx, output int gcyc);
    int n;
    int idx;
    n   = 0;
    idx = -1;
    #1;
    while (req_ready == '0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_grant_seen"}, 32'(req_ready != '0), 32'd1);
    check({name, "_grant_onehot"}, 32'($countones(req_ready)), 32'd1);
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) idx = i;
    end
    check({name, "_grant_idx"}, 32'(idx), 32'(exp_idx));
    gcyc = cyc;
  endtask

  task automatic finish_job(input string name, input int gcyc,
                            input logic [15:0] exp_data, input int exp_id);
    int n;
    n = 0;
    #1;
    while (!rsp_valid && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
    check({name, "_lat"}, 32'(cyc - gcyc), 32'(NOPS + 1));
    check({name, "_data"}, 32'(rsp_data), 32'(exp_data));
    check({name, "_id"}, 32'(rsp_id), 32'(exp_id));
    $display("job %s: id=%0d data=%04h lat=%0d", name, rsp_id, rsp_data, cyc - gcyc);
  endtask

  initial begin
    int g;
    int gprev;
    logic [15:0] a;
    logic [15:0] b;

    rst_n     = 1'b0;
    req_valid = '0;
    req_ops   = '0;
    req_sub   = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_data",  32'(rsp_data),  32'd0);
    check("rst_id",    32'(rsp_id),    32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single job: 5 - 3 - 2 + 10 = 10
    @(negedge clk);
    rsp_ready = 1'b1;
    load(0, 16'd5, 16'd3, 16'd2, 16'd10, 4'b0110);
    req_valid = 4'b0001;
    wait_grant("single", 0, g);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("single_busy", 32'(busy), 32'd1);
    check("single_ready_accum", 32'(req_ready), 32'd0);
    finish_job("single", g, 16'd10, 0);

    // Cancellation a+b-a-b = 0 (ptr now 1, only requester 1 valid)
    a = 16'($urandom_range(0, 65535));
    b = 16'($urandom_range(0, 65535));
    load(1, a, b, a, b, 4'b1100);
    req_valid = 4'b0010;
    wait_grant("cancel", 1, g);
    @(negedge clk);
    req_valid = '0;
    finish_job("cancel", g, 16'd0, 1);

    // Wrap: 0xFFFF + 1 = 0x0000
    load(1, 16'hFFFF, 16'd1, 16'd0, 16'd0, 4'b0000);
    req_valid = 4'b0010;
    wait_grant("wrap", 1, g);
    @(negedge clk);
    req_valid = '0;
    finish_job("wrap", g, 16'h0000, 1);

    // Round-robin from a fresh pointer: requester r sums to 11*r + 4
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < NREQ; r++) begin
      load(r, 16'(r + 1), 16'(10 * r), 16'd1, 16'd2, 4'b0000);
    end
    req_valid = 4'b1111;
    gprev = 0;
    for (int j = 0; j < 5; j++) begin
      wait_grant("rr", j % NREQ, g);
      if (j > 0) check("rr_spacing", 32'(g - gprev), 32'(NOPS + 2));
      gprev = g;
      finish_job("rr", g, 16'(11 * (j % NREQ) + 4), j % NREQ);
    end
    req_valid = '0;

    // Backpressure: ptr is 1; requester 1 wins, then 3 (next after owner), not 0
    @(negedge clk);
    rsp_ready = 1'b0;
    load(0, 16'd50, 16'd50, 16'd50, 16'd50, 4'b0000);
    load(1, 16'd7, 16'd0, 16'd0, 16'd0, 4'b0000);
    load(3, 16'd1, 16'd1, 16'd1, 16'd1, 4'b0000);
    req_valid = 4'b1011;
    wait_grant("bp", 1, g);
    finish_job("bp", g, 16'd7, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_data",  32'(rsp_data),  32'd7);
      check("bp_hold_id",    32'(rsp_id),    32'd1);
      check("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    wait_grant("bp_next", 3, g);
    finish_job("bp_next", g, 16'd4, 3);
    req_valid = '0;

    // Reset mid-ACCUM at cnt=2 of a job owned by requester 2
    @(negedge clk);
    load(2, 16'd9, 16'd9, 16'd9, 16'd9, 4'b0000);
    req_valid = 4'b0100;
    wait_grant("rstmid", 2, g);
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_valid", 32'(rsp_valid), 32'd0);
    check("rstmid_data",  32'(rsp_data),  32'd0);
    check("rstmid_id",    32'(rsp_id),    32'd0);
    check("rstmid_busy",  32'(busy),      32'd0);
    check("rstmid_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    load(0, 16'd1, 16'd2, 16'd3, 16'd4, 4'b0000);
    load(3, 16'd8, 16'd8, 16'd8, 16'd8, 4'b0000);
    req_valid = 4'b1101;
    wait_grant("after_rst", 0, g);
    @(negedge clk);
    req_valid = '0;
    finish_job("after_rst", g, 16'd10, 0);

    // Input churn during ACCUM: 100 + 200 - 50 + 25 = 275
    load(1, 16'd100, 16'd200, 16'd50, 16'd25, 4'b0100);
    req_valid = 4'b0010;
    wait_grant("churn", 1, g);
    @(negedge clk);
    req_valid = '0;
    load(1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4'b1111);
    finish_job("churn", g, 16'd275, 1);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
